// File: rtl/trigger_seq.sv
// trigger_seq -- multi-stage trigger sequencer for the logic analyzer capture path.
//
// NUM_CH channels are compared against per-channel edge/level conditions. Up to
// NUM_STAGES ordered stages, each an AND of selected channel conditions and the
// protocol trigger, must be met in sequence. A programmable delay follows the
// final stage before the sticky `triggered` output is raised.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   armed              sequencer runs only while high
//   ch_h / ch_l        sampled high/low threshold channel values
//   ch_cfg             5 bits per channel: rise, fall, high, low, don't-care
//   prot_trig          protocol trigger pulse
//   stage_mask         NUM_CH+1 bits per stage (channels, then prot_trig)
//   last_stage         index of the final stage (clamped to NUM_STAGES-1)
//   trig_delay         cycles from final-stage match to `triggered`
//   stage_timeout      per-stage timeout (TRIG_STAGE_TIMEOUT_EN builds only)
//   set_capture_done   clears `triggered`
//   triggered          sticky trigger flag
//   trig_pulse         one-cycle pulse when `triggered` rises
//   cur_stage          stage currently being evaluated
//
// Optional feature macro: TRIG_STAGE_TIMEOUT_EN -- adds a per-stage timeout that
// drops the sequence back to stage 0 when a stage >= 1 waits too long.

module trigger_seq_ch (
  input  logic       i_h,
  input  logic       i_l,
  input  logic       i_prev_h,
  input  logic       i_prev_l,
  input  logic [4:0] i_cfg,
  output logic       o_lvl,
  output logic       o_edge
);
  assign o_edge = (i_cfg[4] & i_h & ~i_prev_h) | (i_cfg[3] & ~i_l & i_prev_l);
  assign o_lvl  = (i_cfg[2] & i_h) | (i_cfg[1] & ~i_l) | i_cfg[0];
endmodule

module trigger_seq #(
  parameter int NUM_CH     = 5,
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16,
  parameter int SW         = $clog2(NUM_STAGES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             armed,
  input  logic [NUM_CH-1:0]                ch_h,
  input  logic [NUM_CH-1:0]                ch_l,
  input  logic [5*NUM_CH-1:0]              ch_cfg,
  input  logic                             prot_trig,
  input  logic [NUM_STAGES*(NUM_CH+1)-1:0] stage_mask,
  input  logic [SW-1:0]                    last_stage,
  input  logic [CNT_W-1:0]                 trig_delay,
  input  logic [CNT_W-1:0]                 stage_timeout,
  input  logic                             set_capture_done,
  output logic                             triggered,
  output logic                             trig_pulse,
  output logic [SW-1:0]                    cur_stage
);
  localparam int MW = NUM_CH + 1;

  typedef enum logic [1:0] {IDLE, STAGE, DELAY, TRIG} state_t;

  state_t                          r_state, w_state_nx;
  logic [SW-1:0]                   r_stage, w_stage_nx;
  logic [MW-1:0]                   r_stk, w_stk_nx;
  logic [CNT_W-1:0]                r_dly, w_dly_nx;
  logic                            r_pulse, w_pulse_nx;
  logic [NUM_CH-1:0]               r_prev_h, r_prev_l;
  logic [NUM_CH-1:0]               w_lvl, w_edge;
  logic [MW-1:0]                   w_hit, w_cond, w_mask;
  logic [NUM_STAGES-1:0][MW-1:0]   w_masks;
  logic [SW-1:0]                   w_last;
  logic                            w_sat, w_final, w_timeout;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trigger_seq_ch u_ch (
      .i_h      (ch_h[i]),
      .i_l      (ch_l[i]),
      .i_prev_h (r_prev_h[i]),
      .i_prev_l (r_prev_l[i]),
      .i_cfg    (ch_cfg[5*i +: 5]),
      .o_lvl    (w_lvl[i]),
      .o_edge   (w_edge[i])
    );
  end

  // Clamp is only needed when the index width can express out-of-range stages.
  if ((1 << SW) > NUM_STAGES) begin : g_clamp
    assign w_last = (last_stage > SW'(NUM_STAGES-1)) ? SW'(NUM_STAGES-1) : last_stage;
  end else begin : g_noclamp
    assign w_last = last_stage;
  end

  // Edge hits and prot_trig may be remembered (sticky); levels count only live.
  assign w_hit   = {prot_trig, w_edge};
  assign w_cond  = {1'b0, w_lvl} | w_hit | r_stk;
  assign w_masks = stage_mask;
  assign w_mask  = w_masks[r_stage];
  assign w_sat   = &(~w_mask | w_cond);
  assign w_final = (r_stage >= w_last);

`ifdef TRIG_STAGE_TIMEOUT_EN
  logic [CNT_W-1:0] r_to;
  assign w_timeout = (r_state == STAGE) && (r_stage != '0) && (stage_timeout != '0) &&
                     ((r_to + CNT_W'(1)) == stage_timeout);
  always_ff @(posedge clk) begin
    if (rst)
      r_to <= '0;
    else if ((r_state == STAGE) && armed && (r_stage != '0) && !w_sat && !w_timeout)
      r_to <= r_to + CNT_W'(1);
    else
      r_to <= '0;
  end
`else
  logic w_unused_to;
  assign w_timeout   = 1'b0;
  assign w_unused_to = ^stage_timeout;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_stage_nx = r_stage;
    w_stk_nx   = r_stk;
    w_dly_nx   = r_dly;
    w_pulse_nx = 1'b0;
    case (r_state)
      IDLE: begin
        w_stage_nx = '0;
        w_stk_nx   = '0;
        if (armed) w_state_nx = STAGE;
      end
      STAGE: begin
        if (!armed) begin
          w_state_nx = IDLE;
          w_stage_nx = '0;
          w_stk_nx   = '0;
        end else if (w_sat) begin
          // The satisfying edge is consumed: nothing carries into the next stage.
          w_stk_nx = '0;
          if (!w_final)
            w_stage_nx = r_stage + SW'(1);
          else if (trig_delay != '0) begin
            w_state_nx = DELAY;
            w_dly_nx   = trig_delay;
          end else if (set_capture_done) begin
            w_state_nx = IDLE;
            w_stage_nx = '0;
          end else begin
            w_state_nx = TRIG;
            w_pulse_nx = 1'b1;
          end
        end else if (w_timeout) begin
          w_stage_nx = '0;
          w_stk_nx   = '0;
        end else begin
          w_stk_nx = r_stk | w_hit;
        end
      end
      DELAY: begin
        w_dly_nx = r_dly - CNT_W'(1);
        if (!armed) begin
          w_state_nx = IDLE;
          w_stage_nx = '0;
          w_dly_nx   = '0;
        end else if (r_dly == CNT_W'(1)) begin
          if (set_capture_done) begin
            w_state_nx = IDLE;
            w_stage_nx = '0;
          end else begin
            w_state_nx = TRIG;
            w_pulse_nx = 1'b1;
          end
        end
      end
      TRIG: begin
        if (set_capture_done) begin
          w_state_nx = IDLE;
          w_stage_nx = '0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_stage_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_stage  <= '0;
      r_stk    <= '0;
      r_dly    <= '0;
      r_pulse  <= 1'b0;
      r_prev_h <= '0;
      r_prev_l <= '1;
    end else begin
      r_state  <= w_state_nx;
      r_stage  <= w_stage_nx;
      r_stk    <= w_stk_nx;
      r_dly    <= w_dly_nx;
      r_pulse  <= w_pulse_nx;
      r_prev_h <= ch_h;
      r_prev_l <= ch_l;
    end
  end

  assign triggered  = (r_state == TRIG);
  assign trig_pulse = r_pulse;
  assign cur_stage  = r_stage;
endmodule

// File: tb/tb_trigger_seq.sv
module tb_trigger_seq;
  localparam int NUM_CH = 5, NUM_STAGES = 4, CNT_W = 16, SW = 2, MW = NUM_CH + 1;
  localparam logic [4:0] C_RISE = 5'b10000, C_FALL = 5'b01000, C_HIGH = 5'b00100, C_DC = 5'b00001;

  logic clk = 1'b0, rst = 1'b1, armed = 1'b0, prot_trig = 1'b0, set_capture_done = 1'b0;
  logic [NUM_CH-1:0] ch_h = '0, ch_l = '1;
  logic [5*NUM_CH-1:0] ch_cfg = '0;
  logic [NUM_STAGES*MW-1:0] stage_mask = '0;
  logic [SW-1:0] last_stage = '0;
  logic [CNT_W-1:0] trig_delay = '0, stage_timeout = '0;
  logic triggered, trig_pulse;
  logic [SW-1:0] cur_stage;
  int errors = 0, checks = 0;

  trigger_seq #(.NUM_CH(NUM_CH), .NUM_STAGES(NUM_STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .armed(armed), .ch_h(ch_h), .ch_l(ch_l), .ch_cfg(ch_cfg),
    .prot_trig(prot_trig), .stage_mask(stage_mask), .last_stage(last_stage),
    .trig_delay(trig_delay), .stage_timeout(stage_timeout),
    .set_capture_done(set_capture_done), .triggered(triggered),
    .trig_pulse(trig_pulse), .cur_stage(cur_stage));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; armed = 1'b0; prot_trig = 1'b0; set_capture_done = 1'b0;
    ch_h = '0; ch_l = '1; ch_cfg = '0; stage_mask = '0; last_stage = '0;
    trig_delay = '0; stage_timeout = '0;
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    armed = 1'b1; ch_h = '1; prot_trig = 1'b1; rst = 1'b1;
    step(2);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_trig got=%b exp=0", triggered); end
    checks++; if (trig_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", trig_pulse); end
    checks++; if (cur_stage !== 2'd0) begin errors++; $display("FAIL reset_stage got=%0d exp=0", cur_stage); end
    do_reset();
  endtask

  task automatic test_single_rise();
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; stage_mask[0 +: MW] = 6'b000010;
    armed = 1'b1; step(3);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rise_pre got=%b exp=0", triggered); end
    ch_h[1] = 1'b1; step(1);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rise_trig got=%b exp=1", triggered); end
    checks++; if (trig_pulse !== 1'b1) begin errors++; $display("FAIL rise_pulse got=%b exp=1", trig_pulse); end
    step(1);
    checks++; if (trig_pulse !== 1'b0) begin errors++; $display("FAIL rise_pulse_end got=%b exp=0", trig_pulse); end
    armed = 1'b0; step(2);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rise_hold got=%b exp=1", triggered); end
    set_capture_done = 1'b1; step(1); set_capture_done = 1'b0;
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rise_clear got=%b exp=0", triggered); end
  endtask

  task automatic test_three_stage();
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; ch_cfg[5*2 +: 5] = C_FALL;
    stage_mask[0 +: MW] = 6'b000010; stage_mask[MW +: MW] = 6'b000100; stage_mask[2*MW +: MW] = 6'b100000;
    last_stage = 2'd2;
    armed = 1'b1; step(2);
    ch_h[1] = 1'b1; step(1);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL seq_s1 got=%0d exp=1", cur_stage); end
    step(2); ch_l[2] = 1'b0; step(1);
    checks++; if (cur_stage !== 2'd2) begin errors++; $display("FAIL seq_s2 got=%0d exp=2", cur_stage); end
    step(3);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL seq_wait got=%b exp=0", triggered); end
    prot_trig = 1'b1; step(1); prot_trig = 1'b0;
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL seq_trig got=%b exp=1", triggered); end
    checks++; if (cur_stage !== 2'd2) begin errors++; $display("FAIL seq_trig_stage got=%0d exp=2", cur_stage); end
    // Out of order: the fall comes first and must not satisfy stage 1 later.
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; ch_cfg[5*2 +: 5] = C_FALL;
    stage_mask[0 +: MW] = 6'b000010; stage_mask[MW +: MW] = 6'b000100; stage_mask[2*MW +: MW] = 6'b100000;
    last_stage = 2'd2;
    armed = 1'b1; step(2);
    ch_l[2] = 1'b0; step(2);
    checks++; if (cur_stage !== 2'd0) begin errors++; $display("FAIL ooo_s0 got=%0d exp=0", cur_stage); end
    ch_h[1] = 1'b1; step(1);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL ooo_adv got=%0d exp=1", cur_stage); end
    step(3);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL ooo_hold got=%0d exp=1", cur_stage); end
  endtask

  task automatic test_delay();
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; stage_mask[0 +: MW] = 6'b000010; trig_delay = 16'd7;
    armed = 1'b1; step(2);
    ch_h[1] = 1'b1; step(1);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL dly_start got=%b exp=0", triggered); end
    step(6);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL dly_early got=%b exp=0", triggered); end
    step(1);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL dly_trig got=%b exp=1", triggered); end
    checks++; if (trig_pulse !== 1'b1) begin errors++; $display("FAIL dly_pulse got=%b exp=1", trig_pulse); end
    // Disarm during the delay: the trigger is abandoned.
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; stage_mask[0 +: MW] = 6'b000010; trig_delay = 16'd7;
    armed = 1'b1; step(2);
    ch_h[1] = 1'b1; step(3);
    armed = 1'b0; step(1);
    checks++; if (cur_stage !== 2'd0) begin errors++; $display("FAIL dly_abort_stage got=%0d exp=0", cur_stage); end
    step(10);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL dly_abort got=%b exp=0", triggered); end
  endtask

  task automatic test_and_sticky();
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; ch_cfg[5*3 +: 5] = C_HIGH;
    stage_mask[0 +: MW] = 6'b001010; stage_mask[MW +: MW] = 6'b100000; last_stage = 2'd1;
    armed = 1'b1; step(2);
    ch_h[1] = 1'b1; step(1);
    checks++; if (cur_stage !== 2'd0) begin errors++; $display("FAIL and_partial got=%0d exp=0", cur_stage); end
    step(4); ch_h[3] = 1'b1; step(1);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL and_adv got=%0d exp=1", cur_stage); end
    // CH1 already high before arming (no edge) and CH3 high alone.
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; ch_cfg[5*3 +: 5] = C_HIGH;
    stage_mask[0 +: MW] = 6'b001010; stage_mask[MW +: MW] = 6'b100000; last_stage = 2'd1;
    ch_h[1] = 1'b1; step(2);
    armed = 1'b1; step(2);
    ch_h[3] = 1'b1; step(4);
    checks++; if (cur_stage !== 2'd0) begin errors++; $display("FAIL and_level_only got=%0d exp=0", cur_stage); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; stage_mask[0 +: MW] = 6'b000010;
    armed = 1'b1; step(2);
    ch_h[1] = 1'b1; set_capture_done = 1'b1; step(1); set_capture_done = 1'b0;
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL clash_trig got=%b exp=0", triggered); end
    checks++; if (trig_pulse !== 1'b0) begin errors++; $display("FAIL clash_pulse got=%b exp=0", trig_pulse); end
    ch_h[1] = 1'b0; step(1);
    ch_h[1] = 1'b1; step(1);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rearm_trig got=%b exp=1", triggered); end
  endtask

  task automatic test_reset_in_delay();
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; stage_mask[0 +: MW] = 6'b000010; stage_mask[MW +: MW] = '0;
    last_stage = 2'd1; trig_delay = 16'd5;
    armed = 1'b1; step(2);
    ch_h[1] = 1'b1; step(1);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL rd_s1 got=%0d exp=1", cur_stage); end
    step(1);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL rd_delay_stage got=%0d exp=1", cur_stage); end
    rst = 1'b1; step(1);
    checks++; if (cur_stage !== 2'd0) begin errors++; $display("FAIL rd_stage got=%0d exp=0", cur_stage); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rd_trig got=%b exp=0", triggered); end
    rst = 1'b0; armed = 1'b0; step(8);
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rd_after got=%b exp=0", triggered); end
  endtask

  task automatic test_cfg_edge();
    do_reset();
    ch_cfg[5*0 +: 5] = C_DC;
    stage_mask[0 +: MW] = 6'b010000; stage_mask[MW +: MW] = 6'b000001; last_stage = 2'd1;
    armed = 1'b1; step(2);
    ch_h[4] = 1'b1; ch_l[4] = 1'b0; step(3);
    checks++; if (cur_stage !== 2'd0) begin errors++; $display("FAIL cfg0_never got=%0d exp=0", cur_stage); end
    stage_mask[0 +: MW] = 6'b000001; step(1);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL dc_adv got=%0d exp=1", cur_stage); end
    step(1);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL dc_trig got=%b exp=1", triggered); end
  endtask

  task automatic test_timeout();
    do_reset();
    ch_cfg[5*1 +: 5] = C_RISE; ch_cfg[5*2 +: 5] = C_FALL;
    stage_mask[0 +: MW] = 6'b000010; stage_mask[MW +: MW] = 6'b000100;
    last_stage = 2'd1; stage_timeout = 16'd4;
    armed = 1'b1; step(2);
    ch_h[1] = 1'b1; step(1);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL to_enter got=%0d exp=1", cur_stage); end
    step(3);
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL to_before got=%0d exp=1", cur_stage); end
    step(1);
`ifdef TRIG_STAGE_TIMEOUT_EN
    checks++; if (cur_stage !== 2'd0) begin errors++; $display("FAIL to_expire got=%0d exp=0", cur_stage); end
`else
    checks++; if (cur_stage !== 2'd1) begin errors++; $display("FAIL to_ignored got=%0d exp=1", cur_stage); end
`endif
    armed = 1'b0; step(1);
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_three_stage();
    test_delay();
    test_and_sticky();
    test_back_to_back();
    test_reset_in_delay();
    test_cfg_edge();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trigger_seq.md
# trigger_seq

Parametrised multi-stage trigger sequencer for the logic analyzer capture path. It generalises the fixed five-channel, single-condition trigger to NUM_CH channels and up to NUM_STAGES ordered stages. Each stage is an AND of selected channel and protocol conditions, and the stages must be satisfied in sequence. A programmable post-trigger delay follows the last stage. The block sits between the channel sampling flops / protocol trigger and the capture controller, and it drives `triggered` exactly as the capture FSM expects.

## Interface
Parameters:
- NUM_CH, 5, number of sampled channels (≥1)
- NUM_STAGES, 4, number of sequence stages (≥2)
- CNT_W, 16, width of the delay and timeout counters
- SW, $clog2(NUM_STAGES), stage index width (derived; not overridden)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- armed  in  1  sequencer runs only while high
- ch_h  in  NUM_CH  sampled high-threshold channel values (CHxHff5 equivalents)
- ch_l  in  NUM_CH  sampled low-threshold channel values (CHxLff5 equivalents)
- ch_cfg  in  5*NUM_CH  per-channel config; channel i at [5i+4:5i]; bit4 = rise, bit3 = fall, bit2 = high, bit1 = low, bit0 = don't-care
- prot_trig  in  1  protocol trigger pulse
- stage_mask  in  NUM_STAGES*(NUM_CH+1)  stage s at [s*(NUM_CH+1) +: NUM_CH+1]; bit i selects channel i; bit NUM_CH selects prot_trig
- last_stage  in  SW  index of the final stage; values >NUM_STAGES-1 clamp to NUM_STAGES-1
- trig_delay  in  CNT_W  cycles between final-stage match and `triggered`
- stage_timeout  in  CNT_W  per-stage timeout (used only under TRIG_STAGE_TIMEOUT_EN; 0 = none)
- set_capture_done  in  1  clears `triggered`
- triggered  out  1  trigger condition seen; sticky
- trig_pulse  out  1  one-cycle pulse on the cycle `triggered` rises
- cur_stage  out  SW  stage currently being evaluated

## Operation
- States: IDLE, STAGE, DELAY, TRIG.
- Transitions:
  - IDLE → STAGE(0) when armed=1.
  - STAGE/DELAY → IDLE when armed=0.
  - TRIG → IDLE on set_capture_done.
- Channel condition i is the OR of its enabled cfg bits:
  - rise: ch_h=1 and prev_h=0.
  - fall: ch_l=0 and prev_l=1.
  - high: ch_h.
  - low: !ch_l.
  - don't-care: constant 1.
  - cfg=0 gives constant 0.
- prev_h/prev_l register every cycle in every state, including reset (reset to 0/1 respectively), so arming never creates a false edge.
- Edge hits (rise/fall) and prot_trig are sticky per stage. A sticky flag sets on a hit while in STAGE and clears on stage advance, on leaving STAGE, or on rst. Level conditions are not sticky.
- Stage s is satisfied in a cycle when every bit selected in its mask has its condition true (current level, or sticky flag OR a hit in the current cycle).
  - An all-zero mask is satisfied immediately.
  - A selected channel with cfg=0 is never satisfied.
- When stage s < last_stage is satisfied, cur_stage advances to s+1. Sticky flags clear; the satisfying edge is consumed and not carried forward.
- When stage = last_stage is satisfied:
  - trig_delay=0: go to TRIG.
  - otherwise: load the delay counter and go to DELAY.
- DELAY counts trig_delay cycles, then goes to TRIG.
- TRIG: triggered=1, held regardless of armed until set_capture_done.
- set_capture_done in the same cycle as a trigger set: clear wins, next state IDLE.
- rst mid-operation: all state clears within one cycle.

## Timing
- Reset values: triggered=0, trig_pulse=0, cur_stage=0, state IDLE, counters 0, sticky flags 0.
- armed rising at edge t: first stage evaluation occurs in cycle t+1.
- Last stage satisfied in cycle t: triggered=1 from edge t+1+trig_delay. trig_pulse is high for that first cycle only.
- Stage advance is one cycle per stage; at most one stage advances per cycle.
- cur_stage reads 0 in IDLE and holds last_stage in DELAY and TRIG.

## Configuration
- TRIG_STAGE_TIMEOUT_EN defined:
  - In STAGE with cur_stage ≥1, a counter increments each cycle and resets on advance.
  - When it reaches a nonzero stage_timeout, the sequencer returns to stage 0 and sticky flags clear.
- TRIG_STAGE_TIMEOUT_EN undefined: the stage_timeout port is present but ignored, and no counter is built.

## Test plan
- NUM_CH=5, stage0 mask=CH1 rise, last_stage=0, trig_delay=0. CH1 0→1 at cycle 10 → triggered=1 and trig_pulse=1 at cycle 11; set_capture_done at 20 → triggered=0 at 21.
- Three stages (CH1 rise, CH2 fall, prot_trig), last_stage=2:
  - events in order at cycles 5/8/12 → triggered at 13.
  - CH2 fall before CH1 rise → no advance past stage 0.
- trig_delay=7, last stage met at cycle 30 → triggered at 38. armed dropped at cycle 34 → no trigger, cur_stage=0.
- Stage mask CH1 rise AND CH3 high: CH1 rises at 10 (sticky), CH3 high at 15 → advance at 16. CH3 high alone → no advance.
- set_capture_done and final-stage match in the same cycle → triggered stays 0. rst asserted in DELAY → all outputs 0 next cycle.
- With TRIG_STAGE_TIMEOUT_EN, stage_timeout=4: stage 1 entered at 10 and unmet → cur_stage=0 at 14. Without the macro → cur_stage stays 1.
